// File: rtl/branch_redirect_unit_pkg.sv
// Shared types and constants for the EX-stage branch redirect unit.
package branch_redirect_unit_pkg;

   typedef enum logic {
      IDLE     = 1'b0,
      REDIRECT = 1'b1
   } state_t;

   typedef enum logic [1:0] {
      CF_NONE = 2'd0,
      CF_BR   = 2'd1,
      CF_JAL  = 2'd2,
      CF_JALR = 2'd3
   } cf_t;

   // Sliced to data_width at the point of use; clears the JALR target LSB.
   localparam logic [63:0] JALR_LSB_MASK = ~64'd1;

endpackage

// File: rtl/branch_target_calc.sv
// Combinational resolution of control-flow type, taken decision and target PC.
module branch_target_calc
   import branch_redirect_unit_pkg::*;
#(
   parameter int data_width = 32
) (
   input  logic                  is_branch,
   input  logic                  is_jal,
   input  logic                  is_jalr,
   input  logic [data_width-1:0] ex_pc,
   input  logic [data_width-1:0] ex_imm,
   input  logic [data_width-1:0] alu_result,
   input  logic                  alu_bcond,
   output cf_t                   cf,
   output logic                  taken,
   output logic [data_width-1:0] target,
   output logic                  misaligned
);

   logic [data_width-1:0] pc_rel;

   assign pc_rel = ex_pc + ex_imm;

   // jalr outranks jal, which outranks a conditional branch
   always_comb begin
      cf     = CF_NONE;
      taken  = 1'b0;
      target = pc_rel;
      if (is_jalr) begin
         cf     = CF_JALR;
         taken  = 1'b1;
         target = alu_result & JALR_LSB_MASK[data_width-1:0];
      end else if (is_jal) begin
         cf    = CF_JAL;
         taken = 1'b1;
      end else if (is_branch) begin
         cf    = CF_BR;
         taken = alu_bcond;
      end
   end

   assign misaligned = taken & (target[1:0] != 2'b00);

endmodule

// File: rtl/branch_redirect_unit.sv
// Resolves EX-stage branches/jumps, issues a registered PC redirect and squashes wrong-path stages.
module branch_redirect_unit
   import branch_redirect_unit_pkg::*;
#(
   parameter int data_width = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  ex_valid,
   input  logic                  ex_stall,
   input  logic                  ex_is_branch,
   input  logic                  ex_is_jal,
   input  logic                  ex_is_jalr,
   input  logic [data_width-1:0] ex_pc,
   input  logic [data_width-1:0] ex_imm,
   input  logic [data_width-1:0] alu_result,
   input  logic                  alu_bcond,
   input  logic                  redirect_ready,
   output logic                  redirect_valid,
   output logic [data_width-1:0] redirect_pc,
   output logic                  flush_ifid,
   output logic                  flush_idex,
   output logic                  flush_exmem,
   output logic                  misalign_err,
   output logic [data_width-1:0] branch_count,
   output logic [data_width-1:0] mispredict_count
);

   localparam logic [data_width-1:0] ONE = 1;

   state_t                state;
   cf_t                   cf;
   logic                  taken;
   logic [data_width-1:0] target;
   logic                  misaligned;
   logic                  resolve;

   branch_target_calc #(.data_width(data_width)) u_calc (
      .is_branch  (ex_is_branch),
      .is_jal     (ex_is_jal),
      .is_jalr    (ex_is_jalr),
      .ex_pc      (ex_pc),
      .ex_imm     (ex_imm),
      .alu_result (alu_result),
      .alu_bcond  (alu_bcond),
      .cf         (cf),
      .taken      (taken),
      .target     (target),
      .misaligned (misaligned)
   );

   assign resolve = ex_valid & ~ex_stall & (cf != CF_NONE);

   always_ff @(posedge clk) begin
      if (!reset) begin
         state            <= IDLE;
         redirect_valid   <= 1'b0;
         redirect_pc      <= '0;
         flush_ifid       <= 1'b0;
         flush_idex       <= 1'b0;
         flush_exmem      <= 1'b0;
         misalign_err     <= 1'b0;
         branch_count     <= '0;
         mispredict_count <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (resolve) begin
                  if (cf == CF_BR && ~&branch_count)
                     branch_count <= branch_count + ONE;
                  if (taken) begin
                     state          <= REDIRECT;
                     redirect_valid <= 1'b1;
                     redirect_pc    <= target;
                     flush_ifid     <= 1'b1;
                     flush_idex     <= 1'b1;
                     flush_exmem    <= 1'b1;
                     if (~&mispredict_count)
                        mispredict_count <= mispredict_count + ONE;
                     if (misaligned)
                        misalign_err <= 1'b1;
                  end
               end
            end
            REDIRECT: begin
               // EX holds wrong-path work here; only the handshake matters
               if (redirect_ready) begin
                  state          <= IDLE;
                  redirect_valid <= 1'b0;
                  flush_ifid     <= 1'b0;
                  flush_idex     <= 1'b0;
                  flush_exmem    <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/branch_redirect_unit.md
Name: branch_redirect_unit

Overview:
- Consumer of the ALU's alu_bcond / result outputs in the EX stage of the 5-stage always-not-taken pipeline.
- Resolves conditional branches, JAL and JALR, and drives a registered PC redirect with a valid/ready handshake.
- Squashes wrong-path instructions in IF/ID, ID/EX and EX/MEM.
- Keeps saturating branch and mispredict counters and a sticky misaligned-target flag.

Parameters:
- data_width, 32, width of PC, immediate, ALU result and counters.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset (asserted when 0)
- ex_valid  in  1  EX stage holds a real instruction
- ex_stall  in  1  EX frozen this cycle; no resolution
- ex_is_branch  in  1  conditional branch in EX
- ex_is_jal  in  1  JAL in EX
- ex_is_jalr  in  1  JALR in EX
- ex_pc  in  data_width  PC of EX instruction
- ex_imm  in  data_width  sign-extended immediate
- alu_result  in  data_width  ALU output C (rs1+imm for JALR)
- alu_bcond  in  1  ALU branch condition
- redirect_ready  in  1  PC register accepts redirect this cycle
- redirect_valid  out  1  redirect pending
- redirect_pc  out  data_width  target PC
- flush_ifid  out  1  squash IF/ID
- flush_idex  out  1  squash ID/EX
- flush_exmem  out  1  squash EX/MEM
- misalign_err  out  1  sticky: taken target with bits[1:0] != 0
- branch_count  out  data_width  resolved conditional branches
- mispredict_count  out  data_width  taken redirects issued

Behaviour:
- Reset (reset==0 at posedge):
  - state=IDLE.
  - All outputs 0, including redirect_pc, both counters and misalign_err.
  - Reset wins over every other event, including mid-REDIRECT.
- Resolve event (IDLE only): ex_valid & ~ex_stall & (ex_is_jalr | ex_is_jal | ex_is_branch).
- Priority when several is_* flags are set: jalr > jal > branch.
- Taken and target per type:
  - jalr: always taken; target = alu_result & ~1.
  - jal: always taken; target = ex_pc + ex_imm (modulo 2^data_width).
  - branch: taken iff alu_bcond; target = ex_pc + ex_imm.
- Not-taken branch:
  - No redirect, no flush; stay IDLE.
  - branch_count += 1 at the next edge.
- Taken event at cycle T, effective at T+1:
  - state=REDIRECT.
  - redirect_valid=1 and redirect_pc=target (registered, stable while pending).
  - flush_ifid, flush_idex and flush_exmem all 1.
  - mispredict_count += 1.
  - branch_count += 1 only if the event was a branch.
  - misalign_err set if target[1:0] != 0. The redirect is still issued.
- REDIRECT state:
  - All EX inputs are ignored (wrong path).
  - All three flushes stay 1 every cycle in REDIRECT, including the handshake cycle.
  - redirect_valid & redirect_ready at a posedge completes the handshake; next cycle: state=IDLE, redirect_valid=0, flushes=0.
  - redirect_pc holds its last value after the handshake; it is don't-care when redirect_valid=0.
  - redirect_ready=0 → remain in REDIRECT indefinitely; target unchanged.
- IDLE with ex_stall=1: no resolution and no counter change. The instruction resolves on the first unstalled cycle.
- ex_valid=0: no action regardless of the is_* flags.
- Counters saturate at all-ones; no wrap.
- misalign_err clears only on reset.
- Minimum redirect latency: 1 cycle from resolve to redirect_valid. Back-to-back taken events are impossible because REDIRECT ignores EX.

Decomposition:
- Shared package holds:
  - state encoding: IDLE=1'b0, REDIRECT=1'b1;
  - control-flow type constants: CF_NONE, CF_BR, CF_JAL, CF_JALR;
  - the JALR LSB mask constant.
- One natural sub-module: branch_target_calc. It is combinational; it takes the is_* flags, ex_pc, ex_imm, alu_result and alu_bcond, and outputs taken, target and misaligned.
- The FSM, registers and counters stay in branch_redirect_unit.

Test Plan:
- Not-taken branch: ex_valid=1, ex_is_branch=1, alu_bcond=0, ex_pc=0x100 → no redirect or flush at T+1; branch_count 0→1; mispredict_count 0.
- Taken branch with immediate ready: ex_pc=0x100, ex_imm=0xFFFFFFF0, alu_bcond=1, redirect_ready=1 → at T+1 redirect_valid=1, redirect_pc=0xF0, all flushes 1, counts 1/1; at T+2 IDLE with all outputs low.
- JALR with LSB and delayed handshake: alu_result=0x2003, ready low 3 cycles →
  - redirect_pc=0x2002 held for 4 cycles with flushes high;
  - EX taken events injected meanwhile are ignored;
  - misalign_err=1.
- Priority and stall: ex_is_jal=1 and ex_is_branch=1 with alu_bcond=0 and ex_stall=1 for 2 cycles → nothing happens; on unstall, JAL redirect to ex_pc+ex_imm; branch_count unchanged.
- Saturation: force mispredict_count=0xFFFFFFFF, issue a taken JAL → count stays 0xFFFFFFFF.
- Reset mid-REDIRECT: reset=0 while redirect_valid=1 and ready=0 → next cycle all outputs 0 and state IDLE; a taken branch after release redirects normally.
